// File: rtl/lambda_loader.sv
// Channel-LLR (lambda) SRAM loader: accepts one frame of raw LLR samples,
// scales and saturates each to 16-bit signed, and writes them to addresses 0..CODE_LEN-1.
module lambda_loader #(
    parameter int unsigned CODE_LEN = 400,
    parameter int unsigned IN_W     = 24,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned AW       = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_release,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_llr,
    output logic            o_ready,
    output logic            o_wen,
    output logic [AW-1:0]   o_waddr,
    output logic [15:0]     o_wdata,
    output logic            o_busy,
    output logic            o_loaded,
    output logic            o_frame_done,
    output logic [AW-1:0]   o_count
);

    localparam int unsigned OUT_W = 16;
    // Comparison width wide enough to hold +/-32767 regardless of IN_W
    localparam int unsigned EXT_W = (IN_W > 17) ? IN_W : 17;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-32767);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_wen;
    logic [AW-1:0]     r_waddr;
    logic [OUT_W-1:0]  r_wdata;
    logic              r_frame_done;
    logic [AW-1:0]     r_count;

    logic              w_hs;
    logic              w_wen_nxt;
    logic              w_clr;
    logic              w_frame_done_nxt;

    logic signed [IN_W-1:0]  w_shift;
    logic signed [EXT_W-1:0] w_ext;
    logic [OUT_W-1:0]        w_sat;

    // Sign-preserving scale followed by symmetric saturation (-32768 never produced)
    always_comb begin
        w_shift = $signed(i_llr) >>> SHIFT;
        w_ext   = EXT_W'(w_shift);
        if (w_ext > SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_ext < SAT_MIN) begin
            w_sat = 16'h8001;
        end else begin
            w_sat = w_ext[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control; abort outranks every other request
    always_comb begin
        w_state_nxt      = r_state;
        w_hs             = 1'b0;
        w_wen_nxt        = 1'b0;
        w_clr            = 1'b0;
        w_frame_done_nxt = 1'b0;

        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = ST_LOAD;
                        w_clr       = 1'b1;
                    end
                end
                ST_LOAD: begin
                    w_hs      = i_valid;
                    w_wen_nxt = i_valid;
                    if (i_valid && (r_count == LAST_ADDR)) begin
                        w_state_nxt      = ST_DONE;
                        w_frame_done_nxt = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_release) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Single register stage between handshake and SRAM write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_count      <= '0;
        end else begin
            r_wen        <= w_wen_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_wen_nxt) begin
                r_waddr <= r_count;
                r_wdata <= w_sat;
            end
            if (w_clr) begin
                r_count <= '0;
            end else if (w_hs) begin
                r_count <= r_count + AW'(1);
            end
        end
    end

    assign o_ready      = (r_state == ST_LOAD);
    assign o_busy       = (r_state == ST_LOAD);
    assign o_loaded     = (r_state == ST_DONE);
    assign o_wen        = r_wen;
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
    assign o_frame_done = r_frame_done;
    assign o_count      = r_count;

endmodule

// File: doc/lambda_loader.md
Name: lambda_loader

Overview:
Upstream feeder for the channel-LLR (lambda) SRAM of the LDPC decoder. It accepts one frame of raw channel LLR samples over a valid/ready stream. Each sample is arithmetically scaled and symmetrically saturated to 16-bit signed, then written to sequential lambda SRAM addresses 0..CODE_LEN-1. It then holds the frame as "loaded" until the decoder core releases it.

Parameters:
CODE_LEN, 400, codeword length = number of lambda words per frame (must be <= SRAM depth, >= 2)
IN_W, 24, width of signed input LLR sample
SHIFT, 0, arithmetic right shift applied before saturation (0..IN_W-2)
AW, 20, SRAM address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse: begin loading a new frame
i_abort  input  1  one-cycle pulse: abandon the current frame, return to idle
i_release  input  1  one-cycle pulse from decoder: loaded frame consumed
i_valid  input  1  input sample valid
i_llr  input  IN_W  signed two's-complement channel LLR
o_ready  output  1  loader accepts a sample this cycle
o_wen  output  1  SRAM write enable (drives SRAM i_wen)
o_waddr  output  AW  SRAM write address
o_wdata  output  16  saturated lambda word
o_busy  output  1  high while in LOAD
o_loaded  output  1  high while in DONE; the frame in SRAM is valid
o_frame_done  output  1  one-cycle pulse on entry to DONE
o_count  output  AW  number of samples accepted in the current frame

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; internal address counter 0.
- States: IDLE, LOAD, DONE. The state is registered.
- IDLE: i_start -> LOAD, clear the counter and o_count. Other inputs are ignored.
- LOAD:
  - o_ready = 1, decoded directly from the state register.
  - A handshake occurs when i_valid && o_ready.
  - Each handshake registers o_wen=1, o_waddr=counter, o_wdata=sat(i_llr) for exactly the next cycle. The counter and o_count increment.
  - No handshake -> o_wen=0 next cycle. Address and data hold their last values.
  - A handshake with counter==CODE_LEN-1 -> DONE next cycle. That final write appears on o_wen in the same cycle DONE is entered.
  - o_ready is 0 from that cycle on.
- DONE: o_loaded=1; o_frame_done=1 for the first DONE cycle only. i_release -> IDLE (o_loaded falls next cycle). i_start is ignored.
- i_abort in any state -> IDLE next cycle. It has priority over i_start, i_release and a simultaneous handshake. On abort, the pending sample is not written and o_wen=0 next cycle.
- i_release and i_start in the same DONE cycle: release takes effect, start is ignored. A new i_start is needed after reaching IDLE.
- The write is issued exactly one cycle after the handshake, with no buffering beyond that single register stage. Back-to-back handshakes give back-to-back writes at consecutive addresses.
- Read/write interaction: o_wen high suppresses SRAM reads. The decoder only reads while o_loaded=1, and o_wen is 0 in DONE except during the entry cycle.
- Arithmetic:
  - s = i_llr >>> SHIFT (sign-preserving).
  - Saturation: s > 32767 -> 16'h7FFF; s < -32767 -> 16'h8001 (symmetric, -32768 never produced); otherwise s[15:0].
- o_count saturates naturally at CODE_LEN (never exceeds it). It is cleared on i_start from IDLE and on abort.
- Reset asserted mid-frame: immediate return to IDLE, o_wen=0 asynchronously. The SRAM contents are undefined for the decoder and o_loaded=0.

Test Plan:
- Full frame, SHIFT=0: pulse i_start, stream 400 samples i_llr=k (0..399) with i_valid held high -> 400 consecutive o_wen cycles, o_waddr=0..399, o_wdata=k. o_frame_done pulses once in the cycle of the addr-399 write. o_loaded=1, o_ready=0, o_count=400.
- Saturation: i_llr=24'h7FFFFF -> 16'h7FFF; 24'h800000 -> 16'h8001; 24'hFFFFFB (-5) -> 16'hFFFB. Repeat with SHIFT=4 and i_llr=24'h0007F0 -> 16'h007F.
- Stalls: toggle i_valid 1,0,0,1,1 in LOAD -> writes only for the 3 valid cycles, at addresses 0,1,2. o_wen is 0 in the gaps; o_count=3.
- Abort: abort after 10 samples with i_valid high in the same cycle -> no 11th write, IDLE next cycle, o_count=0. A following i_start reloads from address 0.
- Release/start collision: in DONE, pulse i_release and i_start together -> IDLE, no new frame. i_start in DONE alone is ignored (o_loaded stays 1).
- Async reset: assert rst_n=0 mid-frame between clock edges -> o_wen, o_ready, o_busy drop immediately. After release of reset the block is in IDLE with all outputs 0.
